// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one 32K x 32 synchronous VRAM between the CPU interface
// bus (absolute priority, fixed 1-cycle read latency) and three round-robin
// fetch clients (layer 0, layer 1, sprites). Every port keeps its last read
// result stable until its next completed read.
module vram_arbiter (
  input  logic        clk,
  input  logic        reset,
  // CPU interface bus
  input  logic [16:0] ib_addr,
  input  logic [7:0]  ib_wrdata,
  input  logic        ib_write,
  input  logic        ib_do_access,
  output logic [7:0]  ib_rddata,
  // layer 0 fetch
  input  logic        l0_req,
  input  logic [14:0] l0_addr,
  output logic        l0_ack,
  output logic [31:0] l0_rddata,
  // layer 1 fetch
  input  logic        l1_req,
  input  logic [14:0] l1_addr,
  output logic        l1_ack,
  output logic [31:0] l1_rddata,
  // sprite fetch
  input  logic        spr_req,
  input  logic [14:0] spr_addr,
  output logic        spr_ack,
  output logic [31:0] spr_rddata,
  // VRAM port
  output logic [14:0] ram_addr,
  output logic [31:0] ram_wrdata,
  output logic [3:0]  ram_wrbytesel,
  output logic        ram_write,
  input  logic [31:0] ram_rddata
);

  typedef enum logic [1:0] {RR_L0 = 2'd0, RR_L1 = 2'd1, RR_SPR = 2'd2} rr_t;
  typedef enum logic [2:0] {
    OWN_NONE = 3'd0, OWN_IB = 3'd1, OWN_L0 = 3'd2, OWN_L1 = 3'd3, OWN_SPR = 3'd4
  } owner_t;

  rr_t        rr;
  owner_t     owner;
  logic [1:0] lane;
  logic [2:0] gnt;
  logic       ib_read;
  logic [7:0] lane_byte;
  logic [7:0]  ib_hold;
  logic [31:0] l0_hold;
  logic [31:0] l1_hold;
  logic [31:0] spr_hold;

  assign ib_read = ib_do_access && !ib_write;

  // Round-robin pick among fetch requests, only when the CPU bus is quiet
  always_comb begin
    gnt = 3'b000;
    if (!ib_do_access) begin
      case (rr)
        RR_L1: begin
          if (l1_req)       gnt = 3'b010;
          else if (spr_req) gnt = 3'b100;
          else if (l0_req)  gnt = 3'b001;
        end
        RR_SPR: begin
          if (spr_req)      gnt = 3'b100;
          else if (l0_req)  gnt = 3'b001;
          else if (l1_req)  gnt = 3'b010;
        end
        default: begin
          if (l0_req)       gnt = 3'b001;
          else if (l1_req)  gnt = 3'b010;
          else if (spr_req) gnt = 3'b100;
        end
      endcase
    end
  end

  assign l0_ack  = gnt[0];
  assign l1_ack  = gnt[1];
  assign spr_ack = gnt[2];

  // Drive the RAM port from the granted requester; idle values otherwise
  always_comb begin
    ram_addr      = '0;
    ram_wrdata    = '0;
    ram_wrbytesel = '0;
    ram_write     = 1'b0;
    if (ib_do_access) begin
      ram_addr = ib_addr[16:2];
      if (ib_write) begin
        ram_wrdata = {4{ib_wrdata}};
        ram_write  = 1'b1;
        case (ib_addr[1:0])
          2'd0:    ram_wrbytesel = 4'b0001;
          2'd1:    ram_wrbytesel = 4'b0010;
          2'd2:    ram_wrbytesel = 4'b0100;
          default: ram_wrbytesel = 4'b1000;
        endcase
      end
    end else if (gnt[0]) begin
      ram_addr = l0_addr;
    end else if (gnt[1]) begin
      ram_addr = l1_addr;
    end else if (gnt[2]) begin
      ram_addr = spr_addr;
    end
  end

  // Round-robin pointer, pending read owner and CPU byte lane
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr    <= RR_L0;
      owner <= OWN_NONE;
      lane  <= 2'd0;
    end else begin
      if (gnt[0])      rr <= RR_L1;
      else if (gnt[1]) rr <= RR_SPR;
      else if (gnt[2]) rr <= RR_L0;

      if (ib_read) begin
        owner <= OWN_IB;
        lane  <= ib_addr[1:0];
      end else if (gnt[0]) begin
        owner <= OWN_L0;
      end else if (gnt[1]) begin
        owner <= OWN_L1;
      end else if (gnt[2]) begin
        owner <= OWN_SPR;
      end else begin
        owner <= OWN_NONE;
      end
    end
  end

  // Select the CPU byte out of the returning word
  always_comb begin
    case (lane)
      2'd0:    lane_byte = ram_rddata[7:0];
      2'd1:    lane_byte = ram_rddata[15:8];
      2'd2:    lane_byte = ram_rddata[23:16];
      default: lane_byte = ram_rddata[31:24];
    endcase
  end

  // Capture returning read data into the owner's hold register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ib_hold  <= '0;
      l0_hold  <= '0;
      l1_hold  <= '0;
      spr_hold <= '0;
    end else begin
      if (owner == OWN_IB)  ib_hold  <= lane_byte;
      if (owner == OWN_L0)  l0_hold  <= ram_rddata;
      if (owner == OWN_L1)  l1_hold  <= ram_rddata;
      if (owner == OWN_SPR) spr_hold <= ram_rddata;
    end
  end

  assign ib_rddata  = (owner == OWN_IB)  ? lane_byte  : ib_hold;
  assign l0_rddata  = (owner == OWN_L0)  ? ram_rddata : l0_hold;
  assign l1_rddata  = (owner == OWN_L1)  ? ram_rddata : l1_hold;
  assign spr_rddata = (owner == OWN_SPR) ? ram_rddata : spr_hold;

endmodule
